// File: rtl/selected_card_overlay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : selected_card_overlay
//  Purpose  : Overlays the selected-card highlight sprite on the 256x240
//             raster. Hit-tests each pixel against the sprite window, reads
//             the sprite RAM and merges the returned colour over the
//             background, with transparency, frame-latched position and
//             frame-counted blink.
//  Ports    : clock, reset_n (sync, active-low)
//             pix_valid/pix_x/pix_y/bg_color/hsync_in/vsync_in : raster in
//             frame_start                 : start-of-vblank pulse
//             card_x/card_y/show          : requested sprite position/enable
//             RE/rAddr/dataOut            : sprite RAM read port
//             pix_out/valid_out/hsync_out/vsync_out : merged output, +3 clk
//  Revision : 1.0  initial release
// ============================================================================
module selected_card_overlay #(
    parameter int         SPR_W        = 16,
    parameter int         SPR_H        = 32,
    parameter logic [2:0] TRANSPARENT  = 3'b000,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pix_valid,
    input  logic [7:0] pix_x,
    input  logic [7:0] pix_y,
    input  logic [2:0] bg_color,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       frame_start,
    input  logic [7:0] card_x,
    input  logic [7:0] card_y,
    input  logic       show,
    output logic       RE,
    output logic [8:0] rAddr,
    input  logic [2:0] dataOut,
    output logic [2:0] pix_out,
    output logic       valid_out,
    output logic       hsync_out,
    output logic       vsync_out
);

    localparam int c_DX_BITS = $clog2(SPR_W);
    localparam int c_DY_BITS = $clog2(SPR_H);
    localparam int c_CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BLINK_FRAMES - 1);

    // Frame-latched copies of the requested position; only frame_start
    // updates them so the sprite never moves mid-frame.
    logic [7:0]         r_sh_x;
    logic [7:0]         r_sh_y;
    logic               r_sh_show;
    logic [c_CNT_W-1:0] r_blink_cnt;
    logic               r_blink_on;

    // Stage-1 / stage-2 sideband and hit flags
    logic       r_hit1, r_valid1, r_hs1, r_vs1;
    logic [2:0] r_bg1;
    logic       r_hit2, r_valid2, r_hs2, r_vs2;
    logic [2:0] r_bg2;

    logic [8:0] w_dx;
    logic [8:0] w_dy;
    logic       w_hit;
    logic [8:0] w_addr;

    // 9-bit differences: the >= tests reject pixels left/above the sprite,
    // so a sprite near the right/bottom edge clips instead of wrapping.
    always_comb begin
        w_dx   = {1'b0, pix_x} - {1'b0, r_sh_x};
        w_dy   = {1'b0, pix_y} - {1'b0, r_sh_y};
        w_hit  = pix_valid && r_sh_show && r_blink_on &&
                 (pix_x >= r_sh_x) && (pix_y >= r_sh_y) &&
                 (w_dx < 9'(SPR_W)) && (w_dy < 9'(SPR_H));
        w_addr = {w_dy[c_DY_BITS-1:0], w_dx[c_DX_BITS-1:0]};
    end

    // Shadow registers and blink counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sh_x      <= 8'd0;
            r_sh_y      <= 8'd0;
            r_sh_show   <= 1'b0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (frame_start) begin
            r_sh_x    <= card_x;
            r_sh_y    <= card_y;
            r_sh_show <= show;
            if (r_blink_cnt == c_CNT_LAST) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Stage 1: RAM request and sideband
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            RE       <= 1'b0;
            rAddr    <= 9'd0;
            r_hit1   <= 1'b0;
            r_valid1 <= 1'b0;
            r_hs1    <= 1'b0;
            r_vs1    <= 1'b0;
            r_bg1    <= 3'd0;
        end else begin
            RE       <= w_hit;
            // Address holds on a miss so the RAM port stays quiet.
            if (w_hit) begin
                rAddr <= w_addr;
            end
            r_hit1   <= w_hit;
            r_valid1 <= pix_valid;
            r_hs1    <= hsync_in;
            r_vs1    <= vsync_in;
            r_bg1    <= bg_color;
        end
    end

    // Stage 2: sideband waits while the RAM registers its read data
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_hit2   <= 1'b0;
            r_valid2 <= 1'b0;
            r_hs2    <= 1'b0;
            r_vs2    <= 1'b0;
            r_bg2    <= 3'd0;
        end else begin
            r_hit2   <= r_hit1;
            r_valid2 <= r_valid1;
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_bg2    <= r_bg1;
        end
    end

    // Stage 3: merge; blanked pixels are forced to black
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pix_out   <= 3'd0;
            valid_out <= 1'b0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            if (!r_valid2) begin
                pix_out <= 3'd0;
            end else if (r_hit2 && (dataOut != TRANSPARENT)) begin
                pix_out <= dataOut;
            end else begin
                pix_out <= r_bg2;
            end
            valid_out <= r_valid2;
            hsync_out <= r_hs2;
            vsync_out <= r_vs2;
        end
    end

endmodule
`default_nettype wire

// File: doc/selected_card_overlay.md
# selected_card_overlay

Downstream consumer of the selected-card sprite RAM in the 256x240 VGA path. Takes the raster pixel stream (coordinates, background colour, syncs), decides per pixel whether it falls inside the highlight sprite for the currently selected card, drives the sprite RAM read port, and merges the returned 3-bit sprite colour over the background with transparency. It also provides tear-free position updates and a frame-counted blink.

## Interface
Parameters:
- SPR_W, 16, sprite width in pixels (power of 2; SPR_W*SPR_H = 512)
- SPR_H, 32, sprite height in pixels
- TRANSPARENT, 3'b000, sprite colour code that shows the background
- BLINK_FRAMES, 30, frames per blink phase (on/off)

Ports:
- clock  in  1  system/pixel clock; all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- pix_valid  in  1  raster pixel is in the active area this cycle
- pix_x  in  8  column, 0..255
- pix_y  in  8  row, 0..239
- bg_color  in  3  background colour for this pixel
- hsync_in, vsync_in  in  1 each  raster syncs aligned with pix_*
- frame_start  in  1  one-cycle pulse at the start of vertical blank
- card_x, card_y  in  8 each  requested sprite top-left position
- show  in  1  highlight enable request
- RE  out  1  sprite RAM read enable
- rAddr  out  9  sprite RAM read address
- dataOut  in  3  sprite RAM read data (valid one cycle after RE)
- pix_out  out  3  merged colour
- valid_out, hsync_out, vsync_out  out  1 each  delayed sideband

## Operation
- Shadow registers: sh_x, sh_y, sh_show load card_x, card_y, show only on a frame_start cycle. Mid-frame input changes have no effect until the next frame_start.
- Blink: 0..BLINK_FRAMES-1 frame counter, incremented on each frame_start. On wrap to 0, toggle blink_on. Overlay is active only when sh_show && blink_on.
- Hit test (stage 1): dx = {1'b0,pix_x} - {1'b0,sh_x}, dy = {1'b0,pix_y} - {1'b0,sh_y}, 9-bit unsigned compare. Hit iff pix_valid, overlay active, pix_x >= sh_x, pix_y >= sh_y, dx < SPR_W, dy < SPR_H. The sprite clips at the right/bottom edge and never wraps to column 0 or row 0.
- On hit: RE=1, rAddr = {dy[4:0], dx[3:0]}. On miss: RE=0, rAddr holds its previous value.
- Merge (stage 3): if the stage-2 hit flag is set and dataOut != TRANSPARENT, then pix_out = dataOut; else pix_out = bg_color (delayed). When valid_out=0, pix_out=0.
- The block never writes the sprite RAM.

## Timing
- Three-stage pipeline. Inputs sampled at edge t. At edge t+1, RE/rAddr/hit1 and sideband are registered. At edge t+2, the RAM registers dataOut and sideband stage 2 is registered. At edge t+3, pix_out/valid_out/hsync_out/vsync_out are registered.
- Latency: exactly 3 clocks for all outputs, including syncs and valid, whether or not the pixel is a hit.
- The block accepts one pixel per clock, with no stalls and no backpressure.
- frame_start during the same cycle as a pixel: that pixel uses the old shadow values. The new values apply from the next cycle.
- Reset (reset_n=0 at an edge) forces the following:
  - pix_out=0, valid_out=0, hsync_out=0, vsync_out=0, RE=0, rAddr=0
  - sh_show=0, sh_x=0, sh_y=0, blink counter=0, blink_on=1
  - all pipeline hit flags cleared
- Reset mid-frame: the pipeline flushes, and the overlay stays off until the first frame_start after reset with show=1.

## Test plan
- Basic hit: show=1, card_x=100, card_y=50, frame_start pulse; RAM entry 0x000=3'b101. Pixel (100,50) -> RE=1, rAddr=0 one cycle later; pix_out=3'b101 three cycles after the input.
- Transparency/miss: entry at dy=1,dx=2 (addr 0x012) = 3'b000, bg=3'b011 -> pix_out=3'b011. Pixel (99,50) -> RE=0, pix_out=bg.
- Edge clip: card_x=250, card_y=230. Pixels (255,230) hit with rAddr=0x005; pixel (0,230) does not hit; row 239 hits with dy=9, row 240 is never presented.
- Tear-free update: change card_x from 100 to 20 mid-frame -> hits remain at column 100 until the next frame_start, then move to column 20.
- Blink: BLINK_FRAMES=2 -> overlay visible in frames 0-1, hidden in frames 2-3, visible again in frames 4-5.
- Reset mid-stream: assert reset_n=0 for 1 cycle during a hit run -> all outputs 0 the next cycle, and no hits until frame_start with show=1.
